// File: rtl/button_conditioner.sv
// Alarm-clock input front end: synchronises and debounces the raw push-buttons and
// slide switches, and turns button presses into one-cycle pulses with up/down hold-to-repeat.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 10000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [2:0] key_n_i,
    input  logic [1:0] sw_i,
    output logic [2:0] btn_level_o,
    output logic [2:0] btn_pulse_o,
    output logic [1:0] sw_o
);

    localparam int NCH     = 5;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ? REPEAT_DELAY_CYCLES
                                                                        : REPEAT_RATE_CYCLES;
    localparam int TMR_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE_CYCLES - 1);
    // Raw order {sw[1:0], key_n[2:0]}; synchronisers idle at the released level.
    localparam logic [NCH-1:0]   SYNC_IDLE  = 5'b00111;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT,
        RPT_LOCK
    } rpt_state_e;

    logic [NCH-1:0]  sync_meta;
    logic [NCH-1:0]  sync_q;
    logic [NCH-1:0]  sample;
    logic [NCH-1:0]  stable;
    logic [DB_W-1:0] db_cnt [NCH];
    logic [2:0]      btn_prev;
    logic [2:0]      rise;
    logic            both_held;

    rpt_state_e       state      [2];
    rpt_state_e       state_next [2];
    logic [TMR_W-1:0] timer      [2];
    logic [TMR_W-1:0] timer_next [2];
    logic [1:0]       rpt_pulse;

    // NOTE: every flop below uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_meta <= SYNC_IDLE;
            sync_q    <= SYNC_IDLE;
        end else begin
            sync_meta <= {sw_i, key_n_i};
            sync_q    <= sync_meta;
        end
    end

    assign sample = {sync_q[4:3], ~sync_q[2:0]};

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable <= '0;
            for (int i = 0; i < NCH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (sample[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sample[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign btn_level_o = stable[2:0];
    assign sw_o        = stable[4:3];
    assign rise        = stable[2:0] & ~btn_prev;
    assign both_held   = stable[1] & stable[2];

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            btn_prev    <= '0;
            btn_pulse_o <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= RPT_IDLE;
                timer[i] <= '0;
            end
        end else begin
            btn_prev    <= stable[2:0];
            btn_pulse_o <= {rpt_pulse, rise[0]};
            for (int i = 0; i < 2; i++) begin
                state[i] <= state_next[i];
                timer[i] <= timer_next[i];
            end
        end
    end

    // Index i drives button i+1 (0 = up, 1 = down); holding both locks out pulses.
    // NOTE: defaults are assigned first so no path through this block infers a latch.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_next[i] = state[i];
            timer_next[i] = timer[i];
            rpt_pulse[i]  = 1'b0;
            if (both_held) begin
                state_next[i] = RPT_LOCK;
                timer_next[i] = '0;
            end else begin
                case (state[i])
                    RPT_IDLE: begin
                        if (rise[i+1]) begin
                            rpt_pulse[i]  = 1'b1;
                            timer_next[i] = '0;
                            state_next[i] = RPT_DELAY;
                        end
                    end
                    RPT_DELAY: begin
                        if (!stable[i+1]) begin
                            state_next[i] = RPT_IDLE;
                            timer_next[i] = '0;
                        end else if (timer[i] == DELAY_LAST) begin
                            rpt_pulse[i]  = 1'b1;
                            timer_next[i] = '0;
                            state_next[i] = RPT_REPEAT;
                        end else begin
                            timer_next[i] = timer[i] + TMR_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (!stable[i+1]) begin
                            state_next[i] = RPT_IDLE;
                            timer_next[i] = '0;
                        end else if (timer[i] == RATE_LAST) begin
                            rpt_pulse[i]  = 1'b1;
                            timer_next[i] = '0;
                        end else begin
                            timer_next[i] = timer[i] + TMR_W'(1);
                        end
                    end
                    RPT_LOCK: begin
                        if (!stable[i+1]) begin
                            state_next[i] = RPT_IDLE;
                            timer_next[i] = '0;
                        end
                    end
                    default: begin
                        state_next[i] = RPT_IDLE;
                        timer_next[i] = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing;
// pulse times are logged per button and compared against hand-derived edge numbers.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key_n;
    logic [1:0] sw;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;
    logic [1:0] sw_lvl;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    int unsigned q_set[$];
    int unsigned q_up[$];
    int unsigned q_down[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES    (DB),
        .REPEAT_DELAY_CYCLES(RD),
        .REPEAT_RATE_CYCLES (RR)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .key_n_i      (key_n),
        .sw_i         (sw),
        .btn_level_o  (btn_level),
        .btn_pulse_o  (btn_pulse),
        .sw_o         (sw_lvl)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N, cyc == N, so pulses seen at the next negedge log N.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (btn_pulse[0]) q_set.push_back(cyc);
        if (btn_pulse[1]) q_up.push_back(cyc);
        if (btn_pulse[2]) q_down.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic clear_q();
        q_set.delete();
        q_up.delete();
        q_down.delete();
    endtask

    int unsigned c;
    int unsigned t0;
    int unsigned rpt_ofs[7] = '{0, 20, 28, 36, 44, 52, 60};

    initial begin
        rst_n = 1'b0;
        key_n = 3'b111;
        sw    = 2'b00;
        repeat (3) @(negedge clk);
        check("reset level", btn_level, 0);
        check("reset pulse", btn_pulse, 0);
        check("reset sw", sw_lvl, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean set press: level at +6, one pulse at +7, nothing on release.
        clear_q();
        c = cyc;
        key_n[0] = 1'b0;
        wait_to(c + 5);
        check("set level before debounce", btn_level[0], 0);
        wait_to(c + 6);
        check("set level", btn_level[0], 1);
        wait_to(c + 20);
        check("set pulse count", q_set.size(), 1);
        check("set pulse edge", q_set[0], c + 7);
        check("set no repeat on up", q_up.size(), 0);
        key_n[0] = 1'b1;
        c = cyc;
        wait_to(c + 6);
        check("set level released", btn_level[0], 0);
        wait_to(c + 12);
        check("set no release pulse", q_set.size(), 1);

        // Bouncing up key, then a steady hold with repeat.
        clear_q();
        for (int k = 0; k < 10; k++) begin
            key_n[1] = k[0];
            repeat (2) @(negedge clk);
        end
        check("bounce no pulse", q_up.size(), 0);
        check("bounce no level", btn_level[1], 0);
        key_n[1] = 1'b0;
        c  = cyc;
        t0 = c + 7;
        wait_to(t0 + 60);
        key_n[1] = 1'b1;
        c = cyc;
        wait_to(c + 5);
        check("up level before release settles", btn_level[1], 1);
        wait_to(c + 6);
        check("up level released", btn_level[1], 0);
        wait_to(c + 20);
        check("up pulse count", q_up.size(), 7);
        for (int i = 0; i < 7; i++) check($sformatf("up pulse %0d", i), q_up[i], t0 + rpt_ofs[i]);

        // Down held, up pressed later: lock until both released.
        clear_q();
        c = cyc;
        key_n[2] = 1'b0;
        wait_to(c + 10);
        key_n[1] = 1'b0;
        wait_to(c + 30);
        key_n[1] = 1'b1;
        wait_to(c + 80);
        check("lock down count", q_down.size(), 1);
        check("lock down edge", q_down[0], c + 7);
        check("lock up count", q_up.size(), 0);
        check("lock levels", btn_level, 3'b100);
        key_n[2] = 1'b1;
        c = cyc;
        wait_to(c + 12);
        check("lock release no pulse", q_down.size(), 1);
        c = cyc;
        key_n[2] = 1'b0;
        wait_to(c + 10);
        check("repress down count", q_down.size(), 2);
        check("repress down edge", q_down[1], c + 7);
        key_n[2] = 1'b1;
        wait_to(c + 20);
        check("repress down final count", q_down.size(), 2);

        // Switch glitch rejected, steady change accepted after 6 edges.
        c = cyc;
        sw[1] = 1'b1;
        wait_to(c + 3);
        sw[1] = 1'b0;
        wait_to(c + 15);
        check("sw glitch", sw_lvl, 2'b00);
        c = cyc;
        sw[1] = 1'b1;
        wait_to(c + 5);
        check("sw before debounce", sw_lvl, 2'b00);
        wait_to(c + 6);
        check("sw alarm", sw_lvl, 2'b10);

        // Reset while up repeats, then re-debounce with up still held.
        clear_q();
        c = cyc;
        key_n[1] = 1'b0;
        wait_to(c + 32);
        check("pre-reset up count", q_up.size(), 2);
        #2 rst_n = 1'b0;
        #1;
        check("async reset level", btn_level, 0);
        check("async reset pulse", btn_pulse, 0);
        check("async reset sw", sw_lvl, 0);
        clear_q();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        wait_to(c + 5);
        check("post-reset level early", btn_level[1], 0);
        wait_to(c + 6);
        check("post-reset level", btn_level[1], 1);
        check("post-reset sw", sw_lvl, 2'b10);
        wait_to(c + 30);
        check("post-reset up count", q_up.size(), 2);
        check("post-reset first pulse", q_up[0], c + 7);
        check("post-reset first repeat", q_up[1], c + 27);
        key_n[1] = 1'b1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
